// File: rtl/rom_template_matcher.sv
// rom_template_matcher: SAD of a template ROM scan against a valid/ready sample stream.
// Define TMPL_MATCH_THRESH_EN to add the threshold input and registered match output.
module rom_template_matcher #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 8,
  parameter int RD_LATENCY  = 1,
  parameter int SCORE_WIDTH = ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  input  logic [DATA_WIDTH-1:0]  sample_data,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_rd_data,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   done
`ifdef TMPL_MATCH_THRESH_EN
  ,
  input  logic [SCORE_WIDTH-1:0] threshold,
  output logic                   match
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCEPT, FIN} state_t;
  state_t state, state_nx;
  logic [1:0] wcnt;
  logic [SCORE_WIDTH-1:0] acc, acc_nx;
  logic [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH-1:0] mag;
  logic hs, last;
  assign sample_ready = state == ACCEPT;
  always_comb begin
    diff = {1'b0, sample_data} - {1'b0, rom_rd_data};
    mag = diff[DATA_WIDTH] ? DATA_WIDTH'(-diff) : diff[DATA_WIDTH-1:0];
    hs = sample_ready & sample_valid;
    last = &rom_addr;
    acc_nx = acc + SCORE_WIDTH'(mag);
    state_nx = state == IDLE   ? (start ? WAIT : IDLE)
             : state == WAIT   ? (wcnt == 2'd1 ? ACCEPT : WAIT)
             : state == ACCEPT ? (hs ? (last ? FIN : WAIT) : ACCEPT)
             : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // rom_addr doubles as the sample index; holding it keeps rom_rd_data stable during stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      rom_addr <= '0;
      score <= '0;
      acc <= '0;
      wcnt <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        busy <= 1'b1;
        rom_addr <= '0;
        acc <= '0;
        wcnt <= 2'(RD_LATENCY);
      end
      if (state == WAIT) wcnt <= wcnt - 2'd1;
      if (hs) begin
        acc <= acc_nx;
        if (last) begin
          score <= acc_nx;
          done <= 1'b1;
          busy <= 1'b0;
        end else begin
          rom_addr <= rom_addr + ADDR_WIDTH'(1);
          wcnt <= 2'(RD_LATENCY);
        end
      end
    end
  end
`ifdef TMPL_MATCH_THRESH_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) match <= 1'b0;
    else if (state == IDLE && start) match <= 1'b0;
    else if (hs && last) match <= acc_nx <= threshold;
`endif
endmodule

// File: tb/tb_rom_template_matcher.sv
// tb_rom_template_matcher: runs RD_LATENCY=1 and RD_LATENCY=2 instances against a
// transaction-level SAD model checked every cycle, plus hand-computed score literals.
module tb_rom_template_matcher;
  localparam int AW = 11, DW = 8, SW = 19, N = 2048;
  logic clk = 1'b0;
  logic tb_rst;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic start [2], valid [2], ready [2], busy [2], done [2];
  logic [DW-1:0] sdata [2];
  logic [AW-1:0] raddr [2];
  logic [SW-1:0] score [2], thr [2];
`ifdef TMPL_MATCH_THRESH_EN
  logic match [2];
`endif
  int rom_mode [2], nhs [2], ndone [2];
  bit en [2], gaps [2], hs_last [2];

  function automatic logic [7:0] rom_byte(int m, logic [AW-1:0] a);
    return m == 0 ? 8'hFF : a[7:0];
  endfunction

  task automatic chk(string name, int g, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, g, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int L = g + 1;
    logic [DW-1:0] pipe [L];
    logic [DW-1:0] rdata;
    rom_template_matcher #(.RD_LATENCY(L)) dut (
      .clk(clk), .rst(tb_rst), .start(start[g]), .busy(busy[g]),
      .sample_data(sdata[g]), .sample_valid(valid[g]), .sample_ready(ready[g]),
      .rom_addr(raddr[g]), .rom_rd_data(rdata), .score(score[g]), .done(done[g])
`ifdef TMPL_MATCH_THRESH_EN
      , .threshold(thr[g]), .match(match[g])
`endif
    );
    // ROM: address registered at the edge, plus L-1 output register stages
    always @(posedge clk) begin
      pipe[0] <= rom_byte(rom_mode[g], raddr[g]);
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign rdata = pipe[L-1];

    initial begin
      int gap;
      gap = 0;
      valid[g] = 1'b0;
      forever begin
        @(posedge clk); #1;
        if (hs_last[g]) gap = gaps[g] ? int'($urandom_range(5, 0)) : 0;
        if (gap > 0) begin
          valid[g] = 1'b0;
          gap--;
        end else valid[g] = en[g];
      end
    end

    // model state reflects all edges so far; compared at negedge, then advanced by the coming edge
    initial begin
      bit eb, ed, er, fin;
      logic [AW-1:0] ea;
      logic [SW-1:0] es;
      int acc, quiet, d;
`ifdef TMPL_MATCH_THRESH_EN
      bit em;
      em = 1'b0;
`endif
      eb = 0; ed = 0; er = 0; ea = '0; es = '0; acc = 0; quiet = 0;
      forever begin
        @(negedge clk);
        if (tb_rst) begin
          eb = 0; ed = 0; er = 0; ea = '0; es = '0; acc = 0; quiet = 0;
`ifdef TMPL_MATCH_THRESH_EN
          em = 1'b0;
`endif
        end
        chk("busy", g, busy[g], eb);
        chk("done", g, done[g], ed);
        chk("sample_ready", g, ready[g], er);
        chk("rom_addr", g, raddr[g], ea);
        chk("score", g, score[g], es);
`ifdef TMPL_MATCH_THRESH_EN
        chk("match", g, match[g], em);
`endif
        if (done[g] === 1'b1) ndone[g]++;
        hs_last[g] = !tb_rst && er && valid[g];
        fin = ed;
        ed = 1'b0;
        if (tb_rst) quiet = 0;
        else if (hs_last[g]) begin
          d = int'(sdata[g]) - int'(rom_byte(rom_mode[g], ea));
          acc += d < 0 ? -d : d;
          nhs[g]++;
          if (ea == AW'(N - 1)) begin
            es = SW'(acc);
            eb = 1'b0;
            ed = 1'b1;
`ifdef TMPL_MATCH_THRESH_EN
            em = acc <= int'(thr[g]);
`endif
          end else begin
            ea++;
            quiet = L;
          end
        end else if (quiet > 0) quiet--;
        else if (start[g] && !eb && !fin) begin
          eb = 1'b1; ea = '0; acc = 0; quiet = L; nhs[g] = 0;
`ifdef TMPL_MATCH_THRESH_EN
          em = 1'b0;
`endif
        end
        er = eb && quiet == 0;
      end
    end
  end

  task automatic scan(input int g, input int rm, input logic [7:0] sv, input bit gp,
                      input logic [SW-1:0] th, input int lit, input bit lm, input bit restart);
    int d0, c;
    rom_mode[g] = rm; sdata[g] = sv; gaps[g] = gp; thr[g] = th; en[g] = 1'b1;
    d0 = ndone[g];
    @(posedge clk); #1 start[g] = 1'b1;
    @(posedge clk); #1 start[g] = 1'b0;
    c = 0;
    while (ndone[g] == d0 && c < 40000) begin
      @(posedge clk); #1 start[g] = restart && c == 1500;
      c++;
    end
    chk("scan_timeout", g, c < 40000, 1);
    repeat (10) @(negedge clk);
    chk("score_literal", g, score[g], lit);
    chk("done_pulses", g, ndone[g] - d0, 1);
    chk("handshakes", g, nhs[g], N);
    chk("addr_end", g, raddr[g], N - 1);
`ifdef TMPL_MATCH_THRESH_EN
    chk("match_literal", g, match[g], lm);
`else
    if (lm) chk("thresh_unused", g, th, th + 0);
`endif
    en[g] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int c;
    tb_rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start[g] = 0; en[g] = 0; gaps[g] = 0; rom_mode[g] = 0; sdata[g] = 0; thr[g] = 0;
      nhs[g] = 0; ndone[g] = 0; hs_last[g] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("reset_busy", g, busy[g], 0);
      chk("reset_ready", g, ready[g], 0);
      chk("reset_addr", g, raddr[g], 0);
      chk("reset_score", g, score[g], 0);
    end
    @(posedge clk); #1 tb_rst = 1'b0;
    scan(0, 0, 8'hFF, 0, 0, 0, 1, 0);
    scan(0, 0, 8'h00, 0, 522239, 522240, 0, 0);
    scan(0, 1, 8'h80, 0, 200000, 131072, 1, 0);
    scan(1, 1, 8'h80, 1, 131071, 131072, 0, 0);
    // abort a scan after 1000 samples with reset
    rom_mode[0] = 1; sdata[0] = 8'h80; en[0] = 1'b1; gaps[0] = 0;
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    c = 0;
    while (nhs[0] < 1000 && c < 5000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("mid_reach", 0, c < 5000, 1);
    tb_rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 0, busy[0], 0);
    chk("mid_rst_ready", 0, ready[0], 0);
    chk("mid_rst_addr", 0, raddr[0], 0);
    chk("mid_rst_score", 0, score[0], 0);
    chk("mid_rst_done", 0, done[0], 0);
    @(posedge clk); #1 tb_rst = 1'b0;
    en[0] = 1'b0;
    @(posedge clk); #1;
    scan(0, 1, 8'h80, 0, 131072, 131072, 1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
